// File: rtl/dff_resp_checker.sv
// dff_resp_checker: on-line checker for a single-bit D flop with active-high reset.
// Watches the flop's d/q/qb and its reset. It flags three kinds of error:
//   COMPL  qb is not the complement of q.
//   RST    q is not 0 while the flop's reset is held.
//   DATA   q does not follow d one clock later.
// It keeps the first error code, sticky and pulsed error flags, and saturating counters.
// Ports:
//   clk        checker clock (same clock as the observed flop)
//   reset_n    async active-low checker reset
//   en         enable checking
//   dut_reset  observed flop's active-high reset
//   d, q, qb   observed flop's data input and outputs
//   err        sticky error flag, cleared only by reset_n
//   err_pulse  one-cycle strobe on every error cycle
//   err_code   first error: 0 none, 1 COMPL, 2 RST, 3 DATA
//   check_cnt  cycles on which at least one check ran (saturating)
//   err_cnt    cycles on which an error was flagged (saturating)
//   state      0 IDLE, 1 RESET, 2 TRACK, 3 HALT
module dff_resp_checker #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned RST_LAT     = 1,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dut_reset,
    input  logic             d,
    input  logic             q,
    input  logic             qb,
    output logic             err,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam int unsigned     RC_W    = (RST_LAT < 2) ? 1 : $clog2(RST_LAT + 1);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(RST_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] CODE_COMPL = 2'd1;
    localparam logic [1:0] CODE_RST   = 2'd2;
    localparam logic [1:0] CODE_DATA  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_TRACK = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          cur_state, nxt_state;
    logic            d_q, d_q_nxt;
    logic            d_vld, d_vld_nxt;
    logic [RC_W-1:0] rst_cnt, rst_cnt_nxt;
    logic [RC_W-1:0] rst_cnt_inc;
    logic [RC_W-1:0] rst_cnt_eff;
    logic [RC_W-1:0] rst_cnt_one;
    logic            compl_act, rst_act, data_act;
    logic            compl_fail, rst_fail, data_fail, any_fail;
    logic [1:0]      fail_code;
    logic [CNT_W-1:0] check_cnt_nxt, err_cnt_nxt;

    assign state = cur_state;

    // Saturating reset-sample count helpers; the entry sample into RESET counts as one.
    assign rst_cnt_inc = (rst_cnt < RC_MAX) ? rst_cnt + RC_W'(1) : rst_cnt;
    assign rst_cnt_one = (RC_MAX != '0) ? RC_W'(1) : '0;
    assign rst_cnt_eff = dut_reset ? rst_cnt_inc : rst_cnt;

    // Next-state, check enables and tracking registers.
    always_comb begin
        nxt_state   = cur_state;
        d_q_nxt     = d_q;
        d_vld_nxt   = d_vld;
        rst_cnt_nxt = rst_cnt;
        compl_act   = 1'b0;
        rst_act     = 1'b0;
        data_act    = 1'b0;

        case (cur_state)
            S_IDLE: begin
                if (en) begin
                    if (dut_reset) begin
                        nxt_state   = S_RESET;
                        rst_cnt_nxt = rst_cnt_one;
                    end else begin
                        nxt_state = S_TRACK;
                        d_vld_nxt = 1'b0;
                    end
                end
            end
            S_RESET: begin
                if (!en) begin
                    nxt_state = S_IDLE;
                    d_vld_nxt = 1'b0;
                end else begin
                    compl_act = 1'b1;
                    rst_act   = (rst_cnt_eff >= RC_MAX);
                    if (dut_reset) begin
                        rst_cnt_nxt = rst_cnt_inc;
                    end else begin
                        nxt_state = S_TRACK;
                        d_q_nxt   = d;
                        d_vld_nxt = 1'b1;
                    end
                end
            end
            S_TRACK: begin
                if (!en) begin
                    nxt_state = S_IDLE;
                    d_vld_nxt = 1'b0;
                end else begin
                    compl_act = 1'b1;
                    data_act  = d_vld;
                    if (dut_reset) begin
                        nxt_state   = S_RESET;
                        rst_cnt_nxt = rst_cnt_one;
                        d_vld_nxt   = 1'b0;
                    end else begin
                        d_q_nxt   = d;
                        d_vld_nxt = 1'b1;
                    end
                end
            end
            default: begin
                nxt_state = S_HALT;
            end
        endcase

        compl_fail = compl_act && (qb == q);
        rst_fail   = rst_act && q;
        data_fail  = data_act && (q != d_q);
        any_fail   = compl_fail || rst_fail || data_fail;

        if (compl_fail) begin
            fail_code = CODE_COMPL;
        end else if (rst_fail) begin
            fail_code = CODE_RST;
        end else begin
            fail_code = CODE_DATA;
        end

        // Halting on an error overrides any reset/enable transition on the same sample.
        if (any_fail && STOP_ON_ERR) begin
            nxt_state = S_HALT;
        end

        check_cnt_nxt = (compl_act && (check_cnt != CNT_MAX)) ? check_cnt + CNT_W'(1) : check_cnt;
        err_cnt_nxt   = (any_fail && (err_cnt != CNT_MAX)) ? err_cnt + CNT_W'(1) : err_cnt;
    end

    // State, tracking and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= S_IDLE;
            d_q       <= 1'b0;
            d_vld     <= 1'b0;
            rst_cnt   <= '0;
            err       <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= 2'd0;
            check_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;
            d_q       <= d_q_nxt;
            d_vld     <= d_vld_nxt;
            rst_cnt   <= rst_cnt_nxt;
            err       <= err | any_fail;
            err_pulse <= any_fail;
            if (!err && any_fail) begin
                err_code <= fail_code;
            end
            check_cnt <= check_cnt_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_dff_resp_checker.sv
// tb_dff_resp_checker: randomized bench for dff_resp_checker.
// Three checker configurations watch one emulated sync-reset flop with occasional
// injected faults. A behavioural model of the checking rules predicts every output.
module tb_dff_resp_checker;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic dut_reset;
    logic d;
    logic q;
    logic qb;

    logic        a_err, a_pulse, b_err, b_pulse, c_err, c_pulse;
    logic [1:0]  a_code, b_code, c_code, a_state, b_state, c_state;
    logic [15:0] a_cc, a_ec, c_cc, c_ec;
    logic [3:0]  b_cc, b_ec;

    always #5 clk = ~clk;

    dff_resp_checker #(.CNT_W(16), .RST_LAT(1), .STOP_ON_ERR(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .dut_reset(dut_reset), .d(d), .q(q), .qb(qb),
        .err(a_err), .err_pulse(a_pulse), .err_code(a_code), .check_cnt(a_cc), .err_cnt(a_ec),
        .state(a_state));

    dff_resp_checker #(.CNT_W(4), .RST_LAT(1), .STOP_ON_ERR(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .dut_reset(dut_reset), .d(d), .q(q), .qb(qb),
        .err(b_err), .err_pulse(b_pulse), .err_code(b_code), .check_cnt(b_cc), .err_cnt(b_ec),
        .state(b_state));

    dff_resp_checker #(.CNT_W(16), .RST_LAT(2), .STOP_ON_ERR(1'b0)) dut_c (
        .clk(clk), .reset_n(reset_n), .en(en), .dut_reset(dut_reset), .d(d), .q(q), .qb(qb),
        .err(c_err), .err_pulse(c_pulse), .err_code(c_code), .check_cnt(c_cc), .err_cnt(c_ec),
        .state(c_state));

    // Observed outputs gathered per instance: field 0 err, 1 pulse, 2 code, 3 check_cnt, 4 err_cnt, 5 state.
    logic [31:0] obs [3][6];
    assign obs[0][0] = 32'(a_err);
    assign obs[0][1] = 32'(a_pulse);
    assign obs[0][2] = 32'(a_code);
    assign obs[0][3] = 32'(a_cc);
    assign obs[0][4] = 32'(a_ec);
    assign obs[0][5] = 32'(a_state);
    assign obs[1][0] = 32'(b_err);
    assign obs[1][1] = 32'(b_pulse);
    assign obs[1][2] = 32'(b_code);
    assign obs[1][3] = 32'(b_cc);
    assign obs[1][4] = 32'(b_ec);
    assign obs[1][5] = 32'(b_state);
    assign obs[2][0] = 32'(c_err);
    assign obs[2][1] = 32'(c_pulse);
    assign obs[2][2] = 32'(c_code);
    assign obs[2][3] = 32'(c_cc);
    assign obs[2][4] = 32'(c_ec);
    assign obs[2][5] = 32'(c_state);

    // Configuration of each instance as seen by the model.
    int p_max  [3] = '{65535, 15, 65535};
    int p_lat  [3] = '{1, 1, 2};
    int p_stop [3] = '{1, 0, 0};

    // Model state: mode 0 idle, 1 reset, 2 track, 3 halt.
    int m_mode [3];
    int m_last [3];
    int m_have [3];
    int m_rsmp [3];
    int m_exp  [3][6];

    int n_vec = 0;
    int n_bad = 0;

    string fld_name [6] = '{"err", "err_pulse", "err_code", "check_cnt", "err_cnt", "state"};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input int i);
        m_mode[i] = 0;
        m_last[i] = 0;
        m_have[i] = 0;
        m_rsmp[i] = 0;
        for (int f = 0; f < 6; f++) m_exp[i][f] = 0;
    endtask

    // One sample of the checking rules for instance i, using the values the bench drove.
    task automatic model_step(input int i);
        int code;
        int nxt;
        int seen;
        int qi;
        code = 0;
        qi   = int'(q);
        if (!reset_n) begin
            model_clear(i);
            return;
        end
        if (m_mode[i] == 3) begin
            m_exp[i][1] = 0;
            return;
        end
        nxt = m_mode[i];
        if (m_mode[i] == 0) begin
            if (en) begin
                if (dut_reset) begin
                    nxt = 1;
                    m_rsmp[i] = (p_lat[i] > 0) ? 1 : 0;
                end else begin
                    nxt = 2;
                    m_have[i] = 0;
                end
            end
        end else if (!en) begin
            nxt = 0;
            m_have[i] = 0;
        end else begin
            if (qb == q) code = 1;
            if (m_mode[i] == 1) begin
                seen = dut_reset ? ((m_rsmp[i] + 1 > p_lat[i]) ? p_lat[i] : m_rsmp[i] + 1) : m_rsmp[i];
                if (code == 0 && seen >= p_lat[i] && qi != 0) code = 2;
                if (dut_reset) begin
                    m_rsmp[i] = seen;
                end else begin
                    nxt = 2;
                    m_last[i] = int'(d);
                    m_have[i] = 1;
                end
            end else begin
                if (code == 0 && m_have[i] != 0 && qi != m_last[i]) code = 3;
                if (dut_reset) begin
                    nxt = 1;
                    m_rsmp[i] = (p_lat[i] > 0) ? 1 : 0;
                    m_have[i] = 0;
                end else begin
                    m_last[i] = int'(d);
                    m_have[i] = 1;
                end
            end
            if (m_exp[i][3] < p_max[i]) m_exp[i][3]++;
        end
        m_exp[i][1] = (code != 0) ? 1 : 0;
        if (code != 0) begin
            if (m_exp[i][0] == 0) m_exp[i][2] = code;
            m_exp[i][0] = 1;
            if (m_exp[i][4] < p_max[i]) m_exp[i][4]++;
            if (p_stop[i] != 0) nxt = 3;
        end
        m_mode[i] = nxt;
        m_exp[i][5] = nxt;
    endtask

    task automatic compare_all(input string where);
        for (int i = 0; i < 3; i++) begin
            for (int f = 0; f < 6; f++) begin
                check_val($sformatf("%s dut%0d %s", where, i, fld_name[f]), obs[i][f], 32'(m_exp[i][f]));
            end
        end
    endtask

    logic       flop_q;
    logic [4:0] pat;
    int         fault;

    initial begin
        pat       = 5'b01101;
        reset_n   = 1'b0;
        en        = 1'b0;
        dut_reset = 1'b0;
        d         = 1'b0;
        flop_q    = 1'b0;
        q         = 1'b0;
        qb        = 1'b1;
        for (int i = 0; i < 3; i++) model_clear(i);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Inputs change away from the sampling edge.
            fault = 0;
            if (cyc < 3) begin
                reset_n = 1'b0;
            end else if (cyc < 13) begin
                reset_n = 1'b1;
                en      = 1'b0;
            end else if (cyc < 16) begin
                en        = 1'b1;
                dut_reset = 1'b1;
            end else if (cyc < 21) begin
                dut_reset = 1'b0;
                d         = pat[cyc-16];
            end else if (cyc == 21) begin
                d     = 1'b0;
                fault = 1;
            end else begin
                reset_n = 1'b1;
                en      = ($urandom_range(0, 99) < 92);
                if ($urandom_range(0, 99) < 12) dut_reset = ~dut_reset;
                d = 1'($urandom_range(0, 1));
                if (cyc >= 400 && $urandom_range(0, 99) < 4) fault = int'($urandom_range(1, 2));
            end
            q  = flop_q ^ (fault == 2);
            qb = (fault == 1) ? q : ~q;

            @(posedge clk);
            for (int i = 0; i < 3; i++) model_step(i);
            flop_q = dut_reset ? 1'b0 : d;

            if (cyc >= 300 && (cyc % 250) == 0) begin
                #2;
                reset_n = 1'b0;
                for (int i = 0; i < 3; i++) model_clear(i);
                #1;
                compare_all("async");
            end

            @(negedge clk);
            compare_all($sformatf("cyc%0d", cyc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
